// File: rtl/race_pkg.sv
// Shared definitions for the race sequencer and the physics engines.
//   state_t   : game state codes driven on the state bus
//   WIN_*     : winner codes
//   CPn_*     : checkpoint bounding boxes, min inclusive / max exclusive
package race_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CNT3   = 3'd1,
    ST_CNT2   = 3'd2,
    ST_CNT1   = 3'd3,
    ST_RACE   = 3'd4,
    ST_FINISH = 3'd5
  } state_t;

  localparam logic [1:0] WIN_NONE = 2'd0;
  localparam logic [1:0] WIN_P1   = 2'd1;
  localparam logic [1:0] WIN_P2   = 2'd2;
  localparam logic [1:0] WIN_TIE  = 2'd3;

  // CP0: finish line
  localparam logic [9:0] CP0_X_MIN = 10'd0;
  localparam logic [9:0] CP0_X_MAX = 10'd40;
  localparam logic [9:0] CP0_Y_MIN = 10'd100;
  localparam logic [9:0] CP0_Y_MAX = 10'd140;
  // CP1: top
  localparam logic [9:0] CP1_X_MIN = 10'd140;
  localparam logic [9:0] CP1_X_MAX = 10'd180;
  localparam logic [9:0] CP1_Y_MIN = 10'd10;
  localparam logic [9:0] CP1_Y_MAX = 10'd60;
  // CP2: right
  localparam logic [9:0] CP2_X_MIN = 10'd280;
  localparam logic [9:0] CP2_X_MAX = 10'd320;
  localparam logic [9:0] CP2_Y_MIN = 10'd100;
  localparam logic [9:0] CP2_Y_MAX = 10'd140;
  // CP3: bottom
  localparam logic [9:0] CP3_X_MIN = 10'd140;
  localparam logic [9:0] CP3_X_MAX = 10'd180;
  localparam logic [9:0] CP3_Y_MIN = 10'd180;
  localparam logic [9:0] CP3_Y_MAX = 10'd230;

endpackage

// File: rtl/race_checkpoint_lut.sv
// Combinational checkpoint hit test for one car.
//   cp  : index of the checkpoint the car must reach next
//   x,y : car position in pixels
//   hit : car lies inside that checkpoint's box
module checkpoint_lut
  import race_pkg::*;
(
  input  logic [1:0] cp,
  input  logic [9:0] x,
  input  logic [9:0] y,
  output logic       hit
);

  logic [9:0] x_min, x_max, y_min, y_max;

  always_comb begin
    x_min = CP0_X_MIN;
    x_max = CP0_X_MAX;
    y_min = CP0_Y_MIN;
    y_max = CP0_Y_MAX;
    case (cp)
      2'd1: begin
        x_min = CP1_X_MIN;
        x_max = CP1_X_MAX;
        y_min = CP1_Y_MIN;
        y_max = CP1_Y_MAX;
      end
      2'd2: begin
        x_min = CP2_X_MIN;
        x_max = CP2_X_MAX;
        y_min = CP2_Y_MIN;
        y_max = CP2_Y_MAX;
      end
      2'd3: begin
        x_min = CP3_X_MIN;
        x_max = CP3_X_MAX;
        y_min = CP3_Y_MIN;
        y_max = CP3_Y_MAX;
      end
      default: ;
    endcase
    hit = (x >= x_min) && (x < x_max) && (y >= y_min) && (y < y_max);
  end

endmodule

// File: rtl/race_controller.sv
// Race sequencer for the two-car game: title, 3-2-1 countdown, race with
// checkpoint-ordered lap counting, and finish with winner latch.
//   clk, rst        : system clock, synchronous active-high reset
//   start_btn       : debounced start button level
//   p1_x/y, p2_x/y  : car positions from the physics engines
//   state           : game state bus (physics integrates only in RACE)
//   car_rst         : one-cycle pulse returning cars to the grid
//   countdown       : digit shown during countdown, 0 otherwise
//   p1/p2_lap, _cp  : completed laps and next expected checkpoint
//   winner          : 0 none, 1 car1, 2 car2, 3 tie
//   race_ticks      : race duration in game ticks, saturating
//
// state  | meaning
// IDLE   | title screen, wait for start press
// CNT3   | countdown showing 3
// CNT2   | countdown showing 2
// CNT1   | countdown showing 1
// RACE   | cars move, checkpoints and laps counted each tick
// FINISH | results frozen, start press returns to IDLE
module race_controller
  import race_pkg::*;
#(
  parameter int         CLK_FREQ    = 100_000_000,
  parameter logic [3:0] LAPS        = 4'd3,
  parameter logic [6:0] COUNT_TICKS = 7'd60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_btn,
  input  logic [9:0]  p1_x,
  input  logic [9:0]  p1_y,
  input  logic [9:0]  p2_x,
  input  logic [9:0]  p2_y,
  output logic [2:0]  state,
  output logic        car_rst,
  output logic [1:0]  countdown,
  output logic [3:0]  p1_lap,
  output logic [3:0]  p2_lap,
  output logic [1:0]  p1_cp,
  output logic [1:0]  p2_cp,
  output logic [1:0]  winner,
  output logic [15:0] race_ticks
);

  localparam int TICK_LIMIT = CLK_FREQ / 60;
  localparam int TICK_W     = (TICK_LIMIT > 0) ? $clog2(TICK_LIMIT + 1) : 1;
  localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(TICK_LIMIT);
  localparam logic [TICK_W-1:0] TICK_ONE = TICK_W'(1);

  logic [TICK_W-1:0] tick_cnt;
  logic              tick;
  logic              start_btn_q;
  logic              start_rise;

  state_t      state_q, state_d;
  logic        car_rst_q, car_rst_d;
  logic [1:0]  countdown_q, countdown_d;
  logic [3:0]  p1_lap_q, p1_lap_d, p2_lap_q, p2_lap_d;
  logic [1:0]  p1_cp_q, p1_cp_d, p2_cp_q, p2_cp_d;
  logic [1:0]  winner_q, winner_d;
  logic [15:0] race_ticks_q, race_ticks_d;
  logic [6:0]  step_cnt_q, step_cnt_d;
  logic        p1_hit, p2_hit;
  logic        p1_done, p2_done;

  assign tick       = (tick_cnt == TICK_MAX);
  assign start_rise = start_btn & ~start_btn_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt    <= '0;
      start_btn_q <= 1'b0;
    end else begin
      tick_cnt    <= tick ? '0 : tick_cnt + TICK_ONE;
      start_btn_q <= start_btn;
    end
  end

  checkpoint_lut u_cp_p1 (.cp(p1_cp_q), .x(p1_x), .y(p1_y), .hit(p1_hit));
  checkpoint_lut u_cp_p2 (.cp(p2_cp_q), .x(p2_x), .y(p2_y), .hit(p2_hit));

  // A lap completes only by hitting the finish box while it is the expected one.
  assign p1_done = p1_hit && (p1_cp_q == 2'd0) && ((p1_lap_q + 4'd1) == LAPS);
  assign p2_done = p2_hit && (p2_cp_q == 2'd0) && ((p2_lap_q + 4'd1) == LAPS);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      car_rst_q    <= 1'b0;
      countdown_q  <= 2'd0;
      p1_lap_q     <= 4'd0;
      p2_lap_q     <= 4'd0;
      p1_cp_q      <= 2'd1;
      p2_cp_q      <= 2'd1;
      winner_q     <= WIN_NONE;
      race_ticks_q <= 16'd0;
      step_cnt_q   <= 7'd0;
    end else begin
      state_q      <= state_d;
      car_rst_q    <= car_rst_d;
      countdown_q  <= countdown_d;
      p1_lap_q     <= p1_lap_d;
      p2_lap_q     <= p2_lap_d;
      p1_cp_q      <= p1_cp_d;
      p2_cp_q      <= p2_cp_d;
      winner_q     <= winner_d;
      race_ticks_q <= race_ticks_d;
      step_cnt_q   <= step_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    car_rst_d    = 1'b0;
    p1_lap_d     = p1_lap_q;
    p2_lap_d     = p2_lap_q;
    p1_cp_d      = p1_cp_q;
    p2_cp_d      = p2_cp_q;
    winner_d     = winner_q;
    race_ticks_d = race_ticks_q;
    step_cnt_d   = step_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (start_rise) begin
          state_d      = ST_CNT3;
          car_rst_d    = 1'b1;
          p1_lap_d     = 4'd0;
          p2_lap_d     = 4'd0;
          p1_cp_d      = 2'd1;
          p2_cp_d      = 2'd1;
          winner_d     = WIN_NONE;
          race_ticks_d = 16'd0;
          step_cnt_d   = 7'd0;
        end
      end
      ST_CNT3, ST_CNT2, ST_CNT1: begin
        if (tick) begin
          if (step_cnt_q == COUNT_TICKS - 7'd1) begin
            step_cnt_d = 7'd0;
            case (state_q)
              ST_CNT3: state_d = ST_CNT2;
              ST_CNT2: state_d = ST_CNT1;
              default: state_d = ST_RACE;
            endcase
          end else begin
            step_cnt_d = step_cnt_q + 7'd1;
          end
        end
      end
      ST_RACE: begin
        if (tick) begin
          if (race_ticks_q != 16'hFFFF) race_ticks_d = race_ticks_q + 16'd1;
          if (p1_hit) begin
            if (p1_cp_q == 2'd0) begin
              p1_lap_d = p1_lap_q + 4'd1;
              p1_cp_d  = 2'd1;
            end else begin
              p1_cp_d  = p1_cp_q + 2'd1;
            end
          end
          if (p2_hit) begin
            if (p2_cp_q == 2'd0) begin
              p2_lap_d = p2_lap_q + 4'd1;
              p2_cp_d  = 2'd1;
            end else begin
              p2_cp_d  = p2_cp_q + 2'd1;
            end
          end
          if (p1_done || p2_done) begin
            state_d  = ST_FINISH;
            winner_d = {p2_done, p1_done};
          end
        end
      end
      ST_FINISH: begin
        if (start_rise) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    case (state_d)
      ST_CNT3: countdown_d = 2'd3;
      ST_CNT2: countdown_d = 2'd2;
      ST_CNT1: countdown_d = 2'd1;
      default: countdown_d = 2'd0;
    endcase
  end

  assign state      = state_q;
  assign car_rst    = car_rst_q;
  assign countdown  = countdown_q;
  assign p1_lap     = p1_lap_q;
  assign p2_lap     = p2_lap_q;
  assign p1_cp      = p1_cp_q;
  assign p2_cp      = p2_cp_q;
  assign winner     = winner_q;
  assign race_ticks = race_ticks_q;

endmodule

// File: doc/race_controller.md
Name: race_controller

Overview:
Top-level race sequencer for the two-car game. It owns the game `state` bus that both physics engines consume; the physics engines only integrate motion while state = RACE (3'd4). It consumes each car's `pos_x`/`pos_y` from the physics engines and runs four phases: title, 3-2-1 countdown, race with checkpoint-ordered lap counting, and finish with winner latch. It also pulses a car reset so both physics engines return to their start positions before each race.

Parameters:
CLK_FREQ, 100_000_000, system clock in Hz; game tick period = CLK_FREQ/60 + 1 cycles.
LAPS, 4'd3, laps needed to win (1..15).
COUNT_TICKS, 7'd60, game ticks per countdown step.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
start_btn  in  1  debounced, synchronous start button (level)
p1_x  in  10  car 1 position x (pixels)
p1_y  in  10  car 1 position y
p2_x  in  10  car 2 position x
p2_y  in  10  car 2 position y
state  out  3  game state to physics engines and renderer
car_rst  out  1  one-cycle pulse; drives physics engine resets
countdown  out  2  digit to display: 3, 2, 1, or 0
p1_lap  out  4  car 1 completed laps
p2_lap  out  4  car 2 completed laps
p1_cp  out  2  car 1 next expected checkpoint
p2_cp  out  2  car 2 next expected checkpoint
winner  out  2  0 none, 1 car1, 2 car2, 3 tie
race_ticks  out  16  race duration in game ticks, saturating

Behaviour:
- Reset and clock: rst is synchronous, active-high; clock is clk. All outputs are registered.
- Reset values: state=IDLE(0), car_rst=0, countdown=0, laps=0, cp=1, winner=0, race_ticks=0, tick counter=0. The start_btn edge register resets to 0.
- Game tick: counter tick_cnt counts 0..TICK_LIMIT, where TICK_LIMIT = CLK_FREQ/60. The tick asserts for one cycle when tick_cnt==TICK_LIMIT, and the counter returns to 0 on the same edge.
- start_rise = start_btn & ~start_btn_q. It is evaluated on every clk edge, not gated by the tick.
- States: IDLE=0, CNT3=1, CNT2=2, CNT1=3, RACE=4, FINISH=5. Codes 6 and 7 are illegal and go to IDLE on the next edge.
- IDLE:
  - On start_rise, go to CNT3.
  - On the same edge, assert car_rst for exactly 1 cycle.
  - On the same edge, clear laps, cp(=1), winner, race_ticks and step_cnt.
- CNTn:
  - step_cnt increments on each tick.
  - When step_cnt reaches COUNT_TICKS-1 on a tick, step_cnt clears and the state advances: CNT3→CNT2→CNT1→RACE.
  - The countdown output is 3, 2 or 1 matching the state, and 0 in all other states.
  - start_btn is ignored.
- RACE, on each tick:
  - race_ticks += 1, saturating at 16'hFFFF.
  - Each car is tested independently against the bounding box of its next expected checkpoint.
  - Hit with cp≠0: cp <= cp+1 (3 wraps to 0).
  - Hit with cp==0: lap <= lap+1 and cp <= 1.
  - Boxes are visited in the order 1,2,3,0, so re-entering a box already visited has no effect.
- Finish detection: on the tick where a lap reaches LAPS, state goes to FINISH on that same edge.
  - winner = 1 or 2 for the car that reached LAPS.
  - winner = 3 if both reach LAPS on the same tick.
- FINISH:
  - laps, cp, race_ticks and winner are frozen.
  - start_rise goes to IDLE; winner is held until the next start.
- Checkpoint box test: x_min ≤ x < x_max and y_min ≤ y < y_max, using unsigned 10-bit compares.
- Checkpoint boxes (x range, y range):
  - CP0, finish line: x [0,40), y [100,140).
  - CP1, top: x [140,180), y [10,60).
  - CP2, right: x [280,320), y [100,140).
  - CP3, bottom: x [140,180), y [180,230).
- Cars start inside CP0 with cp=1, so the grid start does not count as a lap.
- rst mid-race: everything returns to IDLE immediately; car_rst is not asserted (physics engines share rst).

Decomposition:
- Shared package race_pkg holds:
  - state encodings ST_IDLE..ST_FINISH (also used by PhysicsEngine comparisons);
  - the CP0..CP3 bound constants;
  - winner codes.
- One combinational sub-module, checkpoint_lut: input cp index and x,y; output hit. Instantiate it twice, once per car.

Test Plan:
- Reset with CLK_FREQ=600 (tick every 11 cycles) → state=0, p1_cp=1, winner=0; 20 idle cycles with start_btn=0 → state stays 0.
- start_btn held high for 5 cycles → car_rst high for exactly 1 cycle; state=1, countdown=3; after 60 ticks state=2, after 120 ticks state=3, after 180 ticks state=4 with countdown=0.
- RACE, p1 driven through (160,30)→(300,120)→(160,200)→(20,120) across ticks → p1_cp sequence 2,3,0,1 and p1_lap=1; p1 at (20,120) before visiting CP1 → no lap.
- LAPS=3: p1 completes its 3rd loop while p2 has lap 2 → state=5 on that tick, winner=1, race_ticks frozen; further movement leaves p1_lap at 3.
- Both cars enter CP0 with cp=0 and lap=2 on the same tick → winner=3, state=5.
- rst asserted mid-RACE → next cycle state=0, laps=0, race_ticks=0; a subsequent start_rise in FINISH → state=0 with winner held until the next start.
